mux_4to1: RTL and testbench
===========================

# mux_4to1

Registered 4-to-1 multiplexer selecting one of four equal-width data words by a 2-bit select split across `s1` (MSB) and `s0` (LSB). The selected word is captured on the clock edge and presented on `out` one cycle later, with a valid flag tracking the pipeline stage. The block is a small datapath steering primitive: it sits between operand sources and a downstream consumer that needs a glitch-free, registered result.

## Interface
Parameters:
- `WIDTH`, default 4, bit width of each data input and of `out`.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a`  input  WIDTH  data word selected when {s1,s0}=2'b00.
- `b`  input  WIDTH  data word selected when {s1,s0}=2'b01.
- `c`  input  WIDTH  data word selected when {s1,s0}=2'b10.
- `d`  input  WIDTH  data word selected when {s1,s0}=2'b11.
- `s0`  input  1  select LSB.
- `s1`  input  1  select MSB.
- `in_valid`  input  1  high when inputs and select are to be captured this cycle.
- `out`  output  WIDTH  registered selected word.
- `out_valid`  output  1  high for the cycle after a capture.

## Operation
- Select decode, with s1 as MSB: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
- Selection is a pure word-wide copy: no arithmetic, no width change, no bit reordering.
- On a rising `clk` edge with `rst_n` high:
  - `in_valid`=1: `out` <= selected word; `out_valid` <= 1.
  - `in_valid`=0: `out` holds its previous value; `out_valid` <= 0.
- X/Z on `s0`/`s1` while `in_valid`=1 is illegal stimulus. The design does not need to sanitise it. Verification flags it as an error.
- Data inputs that are not selected have no effect on any output.
- There is no back-pressure. The consumer must accept `out` in the cycle `out_valid` is high.

## Timing
- Reset: `rst_n` low immediately, asynchronously forces `out`=0 and `out_valid`=0, independent of `clk`.
- Reset is released synchronously in effect: the first capture occurs on the first rising edge on which `rst_n` is high.
- Reset asserted mid-stream: any capture in flight is discarded, and both outputs read 0 until after release.
- Latency: exactly 1 cycle from the sampling edge to `out`/`out_valid` update.
- Throughput: one new selection per cycle. Back-to-back `in_valid` cycles produce back-to-back `out_valid`.
- A change of select and data in the same cycle is sampled together. `out` reflects only the values present at the edge.
- `out` never changes between clock edges except on reset assertion, so no combinational path runs from inputs to outputs.

## Test plan
Common data: WIDTH=4, a=4'b0010, b=4'b1001, c=4'b1110, d=4'b0011.

- **Reset:** hold `rst_n`=0 while toggling inputs, with {s1,s0}=10 and `in_valid`=1 -> `out`=0000 and `out_valid`=0 throughout. Assert `rst_n` between edges -> outputs clear immediately.
- **All four selects:** after reset, apply {s1,s0}=10, 11, 00, 01 on consecutive cycles with `in_valid`=1 -> on the following edges `out`=1110, 0011, 0010, 1001, and `out_valid`=1 on each of those cycles.
- **Hold:** capture {s1,s0}=01 (`out`=1001), then drop `in_valid` and change the select to 11 and `b` to 4'b0000 -> `out` stays 1001 and `out_valid`=0.
- **Unselected inputs ignored:** with {s1,s0}=00 held and `in_valid`=1, change b, c and d every cycle -> `out` stays 0010.
- **Reset mid-stream:** during back-to-back captures, pulse `rst_n` low for half a cycle -> `out`=0000 and `out_valid`=0 at once. The first edge after release with {s1,s0}=11 gives `out`=0011.
- **Random regression:** random data, select and `in_valid` over 1000 cycles -> `out` matches a one-cycle-delayed reference mux, and `out_valid` equals `in_valid` delayed by one cycle.

Source files
------------

// File: rtl/mux_4to1_if.sv
// Bus between an operand source and the registered 4-to-1 mux.
// Carries the four data words, the split select, the capture strobe and the registered result.
interface mux_4to1_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             s0;
   logic             s1;
   logic             in_valid;
   logic [WIDTH-1:0] out;
   logic             out_valid;

   // Source side: drives operands and select, observes the result.
   modport master (
      output a, b, c, d, s0, s1, in_valid,
      input  out, out_valid
   );

   // Mux side: consumes operands and select, drives the result.
   modport slave (
      input  a, b, c, d, s0, s1, in_valid,
      output out, out_valid
   );
endinterface

// File: rtl/mux_4to1.sv
// Registered 4-to-1 word mux.
// The select is {s1,s0}. When in_valid is high, the selected word is captured on the rising clock edge.
// out and out_valid are straight register outputs, so no combinational path runs from the inputs to them.
module mux_4to1 #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_4to1_if.slave  bus
);

   logic [1:0]       sel;
   logic [WIDTH-1:0] sel_word;
   logic [WIDTH-1:0] out_d, out_q;
   logic             vld_d, vld_q;

   // Decode the split select into a word choice; the copy is whole-word, with no reordering.
   always_comb begin
      sel      = {bus.s1, bus.s0};
      sel_word = bus.a;
      case (sel)
         2'b00:   sel_word = bus.a;
         2'b01:   sel_word = bus.b;
         2'b10:   sel_word = bus.c;
         2'b11:   sel_word = bus.d;
         default: sel_word = bus.a;
      endcase
   end

   // Next state: load on in_valid, otherwise hold the data; the valid flag tracks in_valid.
   always_comb begin
      out_d = out_q;
      vld_d = bus.in_valid;
      if (bus.in_valid)
         out_d = sel_word;
   end

   // Output registers. Reset clears them at once and discards any capture that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1.
// The reference model indexes an array of the four words by the select value.
// It holds the previous result when in_valid is low.
module tb_mux_4to1;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [W-1:0] exp_out = '0;
   logic         exp_vld = 1'b0;

   mux_4to1_if #(.WIDTH(W)) bus ();

   mux_4to1 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // An unknown select while capturing is illegal stimulus.
   always @(posedge clk) begin
      if (rst_n && bus.in_valid === 1'b1)
         assert (!$isunknown({bus.s1, bus.s0}))
         else $error("illegal select while in_valid");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".out"}, bus.out, exp_out);
      chk({tag, ".vld"}, W'(bus.out_valid), W'(exp_vld));
   endtask

   task automatic drive(input logic [W-1:0] a, b, c, d, input logic [1:0] sel, input logic v);
      bus.a = a; bus.b = b; bus.c = c; bus.d = d;
      bus.s1 = sel[1]; bus.s0 = sel[0];
      bus.in_valid = v;
   endtask

   // Apply one cycle: drive the inputs, take an edge, update the model, then check 1 time unit after the edge.
   task automatic step(input string tag, input logic [W-1:0] a, b, c, d,
                       input logic [1:0] sel, input logic v);
      logic [W-1:0] words [4];
      drive(a, b, c, d, sel, v);
      words[0] = a; words[1] = b; words[2] = c; words[3] = d;
      @(posedge clk);
      if (rst_n) begin
         if (v) exp_out = words[sel];
         exp_vld = v;
      end
      #1;
      check_outs(tag);
   endtask

   localparam logic [W-1:0] DA = 4'b0010, DB = 4'b1001, DC = 4'b1110, DD = 4'b0011;

   initial begin
      drive(DA, DB, DC, DD, 2'b10, 1'b1);
      #1;
      check_outs("reset_t0");

      // Hold reset with the inputs toggling; the outputs must stay clear.
      for (int i = 0; i < 3; i++)
         step("reset_hold", W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'b10, 1'b1);

      // Release between edges.
      #3 rst_n = 1'b1;

      // All four selects back to back.
      step("sel10", DA, DB, DC, DD, 2'b10, 1'b1);
      step("sel11", DA, DB, DC, DD, 2'b11, 1'b1);
      step("sel00", DA, DB, DC, DD, 2'b00, 1'b1);
      step("sel01", DA, DB, DC, DD, 2'b01, 1'b1);

      // Hold: drop in_valid and change the select and b.
      step("hold_cap", DA, DB, DC, DD, 2'b01, 1'b1);
      step("hold", DA, 4'b0000, DC, DD, 2'b11, 1'b0);
      step("hold2", DA, 4'b0000, DC, DD, 2'b11, 1'b0);

      // Changes to unselected inputs have no effect.
      for (int i = 0; i < 4; i++)
         step("unsel", DA, W'($urandom), W'($urandom), W'($urandom), 2'b00, 1'b1);

      // Reset mid-stream: pulse rst_n low for half a cycle.
      step("mid_cap0", DA, DB, DC, DD, 2'b10, 1'b1);
      step("mid_cap1", DA, DB, DC, DD, 2'b01, 1'b1);
      drive(DA, DB, DC, DD, 2'b11, 1'b1);
      #3 rst_n = 1'b0;
      exp_out = '0;
      exp_vld = 1'b0;
      #1;
      check_outs("mid_async");
      #4 rst_n = 1'b1;
      step("mid_release", DA, DB, DC, DD, 2'b11, 1'b1);

      // Random regression.
      for (int i = 0; i < 1000; i++)
         step("rand", W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
